xor_stream_decryptor: RTL and testbench
=======================================

Name: xor_stream_decryptor

Overview:
- Parametrised hardware XOR decryption engine; replaces the software decryption loop currently run on cpu2.
- Ciphertext characters and then key bytes are loaded over one valid/ready byte stream. The stream is driven by the switch-input path or a host.
- Decrypted characters are emitted one per handshake on a valid/ready output stream to the display path.
- Supports a variable message length, a variable key length, and two key modes: repeating key and autokey.

Parameters:
- CHAR_W, 8, bits per character, key byte and output byte.
- MSG_MAX, 8, maximum ciphertext length (buffer depth).
- KEY_MAX, 3, maximum key length (key buffer depth).
- LEN_W, $clog2(MSG_MAX+1), width of the length fields; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- n_reset  in  1  synchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- msg_len  in  LEN_W  ciphertext length; latched on start.
- key_len  in  LEN_W  key length; latched on start.
- mode  in  1  0 = repeating key, 1 = autokey; latched on start.
- in_data  in  CHAR_W  ciphertext byte or key byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  engine accepts in_data this cycle.
- out_data  out  CHAR_W  plaintext byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  marks the final plaintext byte.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a job completes.
- len_err  out  1  last start had illegal lengths.

Behaviour:
- Reset:
  - Sampled on the clock edge only.
  - All outputs go to 0, state to IDLE, counters to 0.
  - Buffer contents are don't-care.
  - Reset mid-job aborts the job; outputs are 0 on the following cycle.
- States: IDLE, LOAD_MSG, LOAD_KEY, DECRYPT, FINISH.
- IDLE:
  - in_ready=0.
  - On start: if msg_len is 0 or >MSG_MAX, or key_len is 0 or >KEY_MAX, set len_err=1 and stay in IDLE.
  - Otherwise: clear len_err, latch msg_len/key_len/mode, go to LOAD_MSG.
- LOAD_MSG:
  - in_ready=1.
  - Each accepted byte (in_valid and in_ready both high) is written to msg_buf[idx], then idx increments.
  - After byte msg_len-1: idx returns to 0, go to LOAD_KEY.
- LOAD_KEY:
  - Same mechanism, writing key_buf.
  - After byte key_len-1: go to DECRYPT.
  - in_ready drops to 0 in the cycle after the last accept.
- DECRYPT:
  - out_valid rises the cycle after the last key byte is accepted; this is the latency.
  - Output index i runs 0..msg_len-1.
  - Repeating mode: p[i] = c[i] ^ key_buf[i mod key_len]. The key index is a wrap counter, not a divider.
  - Autokey mode: p[i] = c[i] ^ key_buf[i] for i<key_len; p[i] = c[i] ^ p[i-key_len] otherwise.
  - Autokey storage: each plaintext byte overwrites msg_buf[i] at its handshake, so p[i-key_len] is read from msg_buf.
  - Registered output: out_data and out_valid are held stable while out_ready=0. Advance only on handshake.
  - Back-to-back handshakes give one byte per cycle.
  - out_last=1 with the final byte only.
- FINISH:
  - Entered after the final handshake.
  - done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- in_valid outside the LOAD states is ignored.
- key_len > msg_len is legal; unused key bytes are loaded and ignored.
- msg_len=1: out_last is asserted together with the first out_valid.

Decomposition:
- Package xor_dec_pkg holds:
  - state_t enum;
  - MODE_REPEAT / MODE_AUTOKEY constants;
  - a function next_key_idx(idx, key_len) implementing the wrap.
- One sub-module, xor_byte_buf: parametrised width/depth register file with synchronous write and combinational read.
  - Instantiated twice: message buffer and key buffer.

Test Plan:
- Repeating key, msg_len=8 (01 14 14 01 03 0b 05 12), key_len=3 (15 15 15) -> out 14 01 01 14 16 1e 10 07; out_last on 07; done pulse one cycle after that handshake.
- Repeating key, msg_len=4 (00 00 00 00), key_len=3 (aa bb cc) -> out aa bb cc aa; confirms key wrap.
- Autokey, msg_len=3 (01 14 14), key_len=1 (15) -> out 14 00 14.
- Back-pressure: out_ready held low 3 cycles at output index 2 of the first test -> out_data stays 01 and out_valid stays 1 throughout; no byte is lost or duplicated.
- start with msg_len=0 (and, separately, key_len=4) -> len_err=1, busy=0, in_ready=0; a following legal start clears len_err.
- n_reset=0 for one edge during DECRYPT at index 3 -> next cycle out_valid=0, busy=0; a subsequent full job produces correct output.

Source files
------------

// File: rtl/xor_dec_pkg.sv
// Shared types and helpers for the XOR stream decryptor.
// Holds the FSM encoding, key-mode constants and the key-index wrap function.
package xor_dec_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_MSG = 3'd1,
    LOAD_KEY = 3'd2,
    DECRYPT  = 3'd3,
    FINISH   = 3'd4
  } state_t;

  localparam logic MODE_REPEAT  = 1'b0;
  localparam logic MODE_AUTOKEY = 1'b1;

  // Wide enough for any length field the top can be parameterised with.
  localparam int IDX_W = 8;

  function automatic logic [IDX_W-1:0] next_key_idx(input logic [IDX_W-1:0] idx,
                                                    input logic [IDX_W-1:0] key_len);
    if (idx >= key_len - IDX_W'(1)) begin
      return '0;
    end
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/xor_byte_buf.sv
// Small register file: synchronous write, RD_PORTS combinational read ports.
// Out-of-range writes are dropped and out-of-range reads return zero.
module xor_byte_buf #(
  parameter int W        = 8,
  parameter int DEPTH    = 8,
  parameter int RD_PORTS = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           clock,
  input  logic                           we,
  input  logic [AW-1:0]                  waddr,
  input  logic [W-1:0]                   wdata,
  input  logic [RD_PORTS-1:0][AW-1:0]    raddr,
  output logic [RD_PORTS-1:0][W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (int'(raddr[p]) < DEPTH) begin
        rdata[p] = mem[raddr[p]];
      end
    end
  end

endmodule

// File: rtl/xor_stream_decryptor.sv
// XOR decryptor: loads ciphertext then key over one stream, emits plaintext (repeating or autokey).
// First byte one cycle after the last key accept; output register holds while out_ready is low.
module xor_stream_decryptor
  import xor_dec_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int MSG_MAX = 8,
  parameter int KEY_MAX = 3,
  localparam int LEN_W  = $clog2(MSG_MAX + 1)
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic [LEN_W-1:0]  key_len,
  input  logic              mode,
  input  logic [CHAR_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CHAR_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              len_err
);

  localparam int MAW = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
  localparam int KAW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, kidx_q, msg_len_q, key_len_q;
  logic              mode_q, len_err_q, out_valid_q;
  logic [CHAR_W-1:0] out_data_q;

  logic              in_fire, out_fire, load_last, out_final, start_ok;
  logic [LEN_W-1:0]  nxt_idx, nxt_kidx, key_addr;
  logic [MAW-1:0]    src_addr;
  logic              use_key;
  logic [CHAR_W-1:0] key_byte, prev_byte, nxt_byte;

  logic              msg_we;
  logic [CHAR_W-1:0] msg_wdata;
  logic [1:0][MAW-1:0]    msg_raddr;
  logic [1:0][CHAR_W-1:0] msg_rdata;
  logic [0:0][KAW-1:0]    key_raddr;
  logic [0:0][CHAR_W-1:0] key_rdata;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign load_last = idx_q == (((state_q == LOAD_MSG) ? msg_len_q : key_len_q) - LEN_W'(1));
  assign out_final = idx_q == (msg_len_q - LEN_W'(1));
  assign start_ok  = (msg_len != '0) && (msg_len <= LEN_W'(MSG_MAX)) &&
                     (key_len != '0) && (key_len <= LEN_W'(KEY_MAX));

  // Index of the byte to be placed in the output register next: 0 while loading the key.
  assign nxt_idx  = (state_q == DECRYPT) ? idx_q + LEN_W'(1) : '0;
  assign nxt_kidx = (state_q == DECRYPT) ?
                    LEN_W'(next_key_idx(IDX_W'(kidx_q), IDX_W'(key_len_q))) : '0;
  assign src_addr = MAW'(nxt_idx - key_len_q);
  assign use_key  = (mode_q == MODE_REPEAT) || (nxt_idx < key_len_q);
  assign key_addr = (mode_q == MODE_REPEAT) ? nxt_kidx : nxt_idx;

  // The first plaintext byte is formed while the last key byte is still being written.
  assign key_byte  = ((state_q == LOAD_KEY) && in_fire && (idx_q == key_addr)) ?
                     in_data : key_rdata[0];
  // With key_len 1 the autokey source is the byte leaving the output register right now.
  assign prev_byte = (key_len_q == LEN_W'(1)) ? out_data_q : msg_rdata[1];
  assign nxt_byte  = msg_rdata[0] ^ (use_key ? key_byte : prev_byte);

  assign msg_we    = ((state_q == LOAD_MSG) && in_fire) || ((state_q == DECRYPT) && out_fire);
  assign msg_wdata = (state_q == LOAD_MSG) ? in_data : out_data_q;
  assign msg_raddr = {src_addr, nxt_idx[MAW-1:0]};
  assign key_raddr = key_addr[KAW-1:0];

  xor_byte_buf #(.W(CHAR_W), .DEPTH(MSG_MAX), .RD_PORTS(2)) u_msg_buf (
    .clock (clock),
    .we    (msg_we),
    .waddr (idx_q[MAW-1:0]),
    .wdata (msg_wdata),
    .raddr (msg_raddr),
    .rdata (msg_rdata)
  );

  xor_byte_buf #(.W(CHAR_W), .DEPTH(KEY_MAX), .RD_PORTS(1)) u_key_buf (
    .clock (clock),
    .we    ((state_q == LOAD_KEY) && in_fire),
    .waddr (idx_q[KAW-1:0]),
    .wdata (in_data),
    .raddr (key_raddr),
    .rdata (key_rdata)
  );

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      kidx_q      <= '0;
      msg_len_q   <= '0;
      key_len_q   <= '0;
      mode_q      <= 1'b0;
      len_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              len_err_q <= 1'b0;
              msg_len_q <= msg_len;
              key_len_q <= key_len;
              mode_q    <= mode;
              idx_q     <= '0;
              kidx_q    <= '0;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        LOAD_MSG: begin
          if (in_fire) begin
            idx_q <= load_last ? '0 : idx_q + LEN_W'(1);
          end
        end
        LOAD_KEY: begin
          if (in_fire) begin
            if (load_last) begin
              idx_q       <= '0;
              kidx_q      <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= nxt_byte;
            end else begin
              idx_q <= idx_q + LEN_W'(1);
            end
          end
        end
        DECRYPT: begin
          if (out_fire) begin
            if (out_final) begin
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              idx_q       <= '0;
              kidx_q      <= '0;
            end else begin
              idx_q      <= nxt_idx;
              kidx_q     <= nxt_kidx;
              out_data_q <= nxt_byte;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && start_ok) state_d = LOAD_MSG;
      end
      LOAD_MSG: begin
        in_ready = 1'b1;
        if (in_fire && load_last) state_d = LOAD_KEY;
      end
      LOAD_KEY: begin
        in_ready = 1'b1;
        if (in_fire && load_last) state_d = DECRYPT;
      end
      DECRYPT: begin
        if (out_fire && out_final) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && out_final;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_xor_stream_decryptor.sv
// Bench for xor_stream_decryptor: directed plan vectors plus randomized jobs
// checked against an array-based reference model of the decryption rules.
module tb_xor_stream_decryptor;

  localparam int MSG_MAX = 8;
  localparam int KEY_MAX = 3;
  localparam int LEN_W   = 4;

  logic             clock = 1'b0;
  logic             n_reset, start, mode, in_valid, in_ready, out_valid, out_ready;
  logic             out_last, busy, done, len_err;
  logic [LEN_W-1:0] msg_len, key_len;
  logic [7:0]       in_data, out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg_a [MSG_MAX];
  logic [7:0] key_a [KEY_MAX];
  logic [7:0] exp_a [MSG_MAX];

  always #5 clock = ~clock;

  xor_stream_decryptor #(.CHAR_W(8), .MSG_MAX(MSG_MAX), .KEY_MAX(KEY_MAX)) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .start     (start),
    .msg_len   (msg_len),
    .key_len   (key_len),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_msg(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) msg_a[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic set_key(input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) key_a[i] = v[8*(n-1-i) +: 8];
  endtask

  // Plaintext straight from the cipher definition.
  task automatic build_expected(input int ml, input int kl, input bit md);
    for (int i = 0; i < ml; i++) begin
      if (!md)         exp_a[i] = msg_a[i] ^ key_a[i % kl];
      else if (i < kl) exp_a[i] = msg_a[i] ^ key_a[i];
      else             exp_a[i] = msg_a[i] ^ exp_a[i-kl];
    end
  endtask

  task automatic try_bad(input int ml, input int kl);
    start = 1'b1; msg_len = LEN_W'(ml); key_len = LEN_W'(kl); mode = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("len_err_set", len_err, 1);
    check("len_err_busy", busy, 0);
    check("len_err_in_ready", in_ready, 0);
    @(negedge clock);
  endtask

  task automatic run_job(input int ml, input int kl, input bit md, input int stall_at,
                         input int stall_n, input int abort_at, input bit rnd);
    int k, stalled, cyc;
    build_expected(ml, kl, md);
    start = 1'b1; msg_len = LEN_W'(ml); key_len = LEN_W'(kl); mode = md;
    @(negedge clock);
    check("start_busy", busy, 1);
    check("start_len_err", len_err, 0);
    for (int i = 0; i < ml + kl; i++) begin
      if (rnd) begin
        for (int g = 0; g < 3 && $urandom_range(3, 0) == 0; g++) begin
          in_valid = 1'b0; in_data = 8'($urandom);
          start = 1'($urandom_range(1, 0)); msg_len = LEN_W'($urandom);
          @(negedge clock);
        end
      end
      in_valid = 1'b1;
      in_data  = (i < ml) ? msg_a[i] : key_a[i-ml];
      start    = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
      check("in_ready_load", in_ready, 1);
      @(negedge clock);
    end
    start = 1'b0; in_valid = 1'b0;
    check("in_ready_drop", in_ready, 0);
    check("first_valid_latency", out_valid, 1);
    k = 0; stalled = 0; cyc = 0;
    while (k < ml && cyc < 300) begin
      if (k == abort_at) begin
        n_reset = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        n_reset = 1'b1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_out_last", out_last, 0);
        check("abort_in_ready", in_ready, 0);
        return;
      end
      if (k == stall_at && stalled < stall_n) begin
        out_ready = 1'b0; stalled++;
      end else begin
        out_ready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      end
      in_valid = 1'($urandom_range(1, 0)); in_data = 8'($urandom);
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_a[k]);
      check("out_last", out_last, (k == ml - 1));
      if (out_ready) k++;
      @(negedge clock);
      cyc++;
    end
    check("output_timeout", (cyc < 300), 1);
    out_ready = 1'b0; in_valid = 1'b0;
    check("done_pulse", done, 1);
    check("done_out_valid", out_valid, 0);
    @(negedge clock);
    check("done_cleared", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset = 1'b0; start = 1'b0; msg_len = '0; key_len = '0; mode = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_len_err", len_err, 0);
    n_reset = 1'b1;
    @(negedge clock);

    // Repeating key, full-length message, with a 3-cycle stall at index 2.
    set_msg(64'h01141401030b0512, 8); set_key(24'h151515, 3);
    run_job(8, 3, 1'b0, 2, 3, -1, 1'b0);

    // Key wrap with a shorter message.
    set_msg(64'h00000000, 4); set_key(24'haabbcc, 3);
    run_job(4, 3, 1'b0, -1, 0, -1, 1'b0);

    // Autokey, single-byte key.
    set_msg(64'h011414, 3); set_key(24'h000015, 1);
    run_job(3, 1, 1'b1, -1, 0, -1, 1'b0);

    // Illegal lengths, then a legal job clears the error.
    try_bad(0, 2);
    try_bad(3, 4);
    set_msg(64'h5a, 1); set_key(24'h0f0102, 3);
    run_job(1, 3, 1'b0, -1, 0, -1, 1'b0);

    // Reset during output at index 3, then a full job.
    set_msg(64'h01141401030b0512, 8); set_key(24'h151515, 3);
    run_job(8, 3, 1'b0, -1, 0, 3, 1'b0);
    @(negedge clock);
    set_msg(64'h0102030405060708, 8); set_key(24'h10203f, 3);
    run_job(8, 3, 1'b1, -1, 0, -1, 1'b0);

    for (int j = 0; j < 30; j++) begin
      int ml, kl;
      ml = $urandom_range(MSG_MAX, 1);
      kl = $urandom_range(KEY_MAX, 1);
      for (int i = 0; i < MSG_MAX; i++) msg_a[i] = 8'($urandom);
      for (int i = 0; i < KEY_MAX; i++) key_a[i] = 8'($urandom);
      run_job(ml, kl, 1'($urandom_range(1, 0)), $urandom_range(MSG_MAX - 1, 0),
              $urandom_range(3, 0), -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
